// File: rtl/wb_ppfifo_2_mem_nbank.sv
// Drains a ping-pong FIFO into N round-robin memory banks through a Wishbone master.
// Optional ack timeout enabled by defining WB_P2M_TIMEOUT_EN.
module wb_ppfifo_2_mem_nbank #(
  parameter int unsigned BANK_BITS      = 2,
  parameter int unsigned ADDR_INC       = 1,
  parameter int unsigned FIFO_SIZE_W    = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic                   i_bank_wr,
  input  logic [BANK_BITS-1:0]   i_bank_sel,
  input  logic [31:0]            i_bank_base,
  input  logic [31:0]            i_bank_size,
  output logic [31:0]            o_bank_base,
  output logic [31:0]            o_bank_count,
  output logic [(2**BANK_BITS)-1:0] o_bank_armed,
  output logic [(2**BANK_BITS)-1:0] o_bank_done,
  output logic [BANK_BITS-1:0]   o_cur_bank,
  output logic                   o_write_finished,
  output logic                   o_error,
  output logic                   o_mem_we,
  output logic                   o_mem_stb,
  output logic                   o_mem_cyc,
  output logic [3:0]             o_mem_sel,
  output logic [31:0]            o_mem_adr,
  output logic [31:0]            o_mem_dat,
  input  logic [31:0]            i_mem_dat,
  input  logic                   i_mem_ack,
  input  logic                   i_mem_int,
  input  logic                   i_ppfifo_rdy,
  output logic                   o_ppfifo_act,
  input  logic [FIFO_SIZE_W-1:0] i_ppfifo_size,
  output logic                   o_ppfifo_stb,
  input  logic [31:0]            i_ppfifo_data
);

  localparam int unsigned NUM_BANKS = 2**BANK_BITS;
  localparam logic [31:0] ADDR_STEP = 32'(ADDR_INC);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, CHECK} state_t;

  state_t                 state;
  logic [31:0]            bank_base  [NUM_BANKS];
  logic [31:0]            bank_size  [NUM_BANKS];
  logic [31:0]            bank_count [NUM_BANKS];
  logic [FIFO_SIZE_W-1:0] blk_size;
  logic [FIFO_SIZE_W-1:0] blk_cnt;

`ifdef WB_P2M_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic unused_ok;
  assign unused_ok = ^{i_mem_dat, i_mem_int};
`else
  logic unused_ok;
  assign unused_ok = ^{i_mem_dat, i_mem_int, 32'(TIMEOUT_CYCLES)};
  assign o_error = 1'b0;
`endif

  // Zero-latency register readback for the host wrapper
  assign o_bank_base  = bank_base[i_bank_sel];
  assign o_bank_count = bank_count[i_bank_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        bank_base[i]  <= '0;
        bank_size[i]  <= '0;
        bank_count[i] <= '0;
      end
      o_bank_armed     <= '0;
      o_bank_done      <= '0;
      o_cur_bank       <= '0;
      o_write_finished <= 1'b0;
      o_mem_we         <= 1'b0;
      o_mem_stb        <= 1'b0;
      o_mem_cyc        <= 1'b0;
      o_mem_sel        <= 4'h0;
      o_mem_adr        <= '0;
      o_mem_dat        <= '0;
      o_ppfifo_act     <= 1'b0;
      o_ppfifo_stb     <= 1'b0;
      blk_size         <= '0;
      blk_cnt          <= '0;
`ifdef WB_P2M_TIMEOUT_EN
      tmo_cnt          <= '0;
      o_error          <= 1'b0;
`endif
    end else begin
      o_ppfifo_stb     <= 1'b0;
      o_write_finished <= 1'b0;
      case (state)
        IDLE: begin
          o_mem_cyc <= 1'b0;
          if (i_enable && o_bank_armed[o_cur_bank]) state <= FETCH;
        end
        FETCH: begin
          if (!i_enable) begin
            o_mem_cyc <= 1'b0;
            state     <= IDLE;
          end else if (!o_ppfifo_act) begin
            if (i_ppfifo_rdy) begin
              o_ppfifo_act <= 1'b1;
              blk_size     <= i_ppfifo_size;
              blk_cnt      <= '0;
            end
          end else if (blk_cnt == blk_size) begin
            // Empty or exhausted block: release it and wait for the next one
            o_ppfifo_act <= 1'b0;
          end else begin
            o_ppfifo_stb <= 1'b1;
            o_mem_dat    <= i_ppfifo_data;
            o_mem_cyc    <= 1'b1;
            o_mem_stb    <= 1'b1;
            o_mem_we     <= 1'b1;
            o_mem_sel    <= 4'hF;
            o_mem_adr    <= bank_base[o_cur_bank] + bank_count[o_cur_bank] * ADDR_STEP;
`ifdef WB_P2M_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (i_mem_ack) begin
            o_mem_stb              <= 1'b0;
            o_mem_we               <= 1'b0;
            o_mem_sel              <= 4'h0;
            bank_count[o_cur_bank] <= bank_count[o_cur_bank] + 32'd1;
            blk_cnt                <= FIFO_SIZE_W'(blk_cnt + 1'b1);
            state                  <= CHECK;
          end
`ifdef WB_P2M_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Slave never answered: abandon the bank without marking it done
            o_mem_stb                <= 1'b0;
            o_mem_we                 <= 1'b0;
            o_mem_sel                <= 4'h0;
            o_mem_cyc                <= 1'b0;
            o_error                  <= 1'b1;
            o_bank_armed[o_cur_bank] <= 1'b0;
            o_ppfifo_act             <= 1'b0;
            state                    <= IDLE;
          end else begin
            tmo_cnt <= TMO_W'(tmo_cnt + 1'b1);
          end
`endif
        end
        CHECK: begin
          if (blk_cnt == blk_size) o_ppfifo_act <= 1'b0;
          if (bank_count[o_cur_bank] == bank_size[o_cur_bank]) begin
            o_bank_armed[o_cur_bank] <= 1'b0;
            o_bank_done[o_cur_bank]  <= 1'b1;
            o_write_finished         <= 1'b1;
            o_mem_cyc                <= 1'b0;
            o_cur_bank               <= BANK_BITS'(o_cur_bank + 1'b1);
            state                    <= IDLE;
          end else if (!i_enable) begin
            o_mem_cyc <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase

      // Host arming only touches idle banks, so it never collides with the FSM
      if (i_bank_wr && (i_bank_size != 32'd0) && !o_bank_armed[i_bank_sel]) begin
        bank_base[i_bank_sel]    <= i_bank_base;
        bank_size[i_bank_sel]    <= i_bank_size;
        bank_count[i_bank_sel]   <= '0;
        o_bank_armed[i_bank_sel] <= 1'b1;
        o_bank_done[i_bank_sel]  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_ppfifo_2_mem_nbank.sv
// Directed bench for wb_ppfifo_2_mem_nbank: 4 banks, word addressing, FWFT FIFO model
// and a zero-wait Wishbone slave whose ack can be withheld.
module tb_wb_ppfifo_2_mem_nbank;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic        i_bank_wr;
  logic [1:0]  i_bank_sel;
  logic [31:0] i_bank_base;
  logic [31:0] i_bank_size;
  logic [31:0] o_bank_base;
  logic [31:0] o_bank_count;
  logic [3:0]  o_bank_armed;
  logic [3:0]  o_bank_done;
  logic [1:0]  o_cur_bank;
  logic        o_write_finished;
  logic        o_error;
  logic        o_mem_we, o_mem_stb, o_mem_cyc;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_adr, o_mem_dat;
  logic        i_mem_ack;
  logic        i_ppfifo_rdy;
  logic        o_ppfifo_act;
  logic [23:0] i_ppfifo_size;
  logic        o_ppfifo_stb;
  logic [31:0] i_ppfifo_data;

  logic        ack_en;
  int          blocks_total;
  int          blocks_used;
  logic        act_q;
  int          wr_n, fin_n, stb_n;
  logic [31:0] wr_adr [64];
  logic [31:0] wr_dat [64];
  int          tests, failed;

  always #5 clk = ~clk;

  wb_ppfifo_2_mem_nbank #(
    .BANK_BITS(2), .ADDR_INC(1), .FIFO_SIZE_W(24), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_bank_wr(i_bank_wr), .i_bank_sel(i_bank_sel),
    .i_bank_base(i_bank_base), .i_bank_size(i_bank_size),
    .o_bank_base(o_bank_base), .o_bank_count(o_bank_count),
    .o_bank_armed(o_bank_armed), .o_bank_done(o_bank_done),
    .o_cur_bank(o_cur_bank), .o_write_finished(o_write_finished), .o_error(o_error),
    .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb), .o_mem_cyc(o_mem_cyc),
    .o_mem_sel(o_mem_sel), .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat),
    .i_mem_dat(32'h0), .i_mem_ack(i_mem_ack), .i_mem_int(1'b0),
    .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act),
    .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(o_ppfifo_stb),
    .i_ppfifo_data(i_ppfifo_data)
  );

  // Zero-wait slave and a FIFO that hands out 4-word blocks of an incrementing sequence
  assign i_mem_ack    = o_mem_stb & ack_en;
  assign i_ppfifo_rdy = (blocks_used < blocks_total) && !o_ppfifo_act;
  assign i_ppfifo_size = 24'd4;

  always @(posedge clk) begin
    if (rst) begin
      i_ppfifo_data <= 32'd0;
      blocks_used   <= 0;
      act_q         <= 1'b0;
      wr_n          <= 0;
      fin_n         <= 0;
      stb_n         <= 0;
    end else begin
      act_q <= o_ppfifo_act;
      if (o_ppfifo_act && !act_q) blocks_used <= blocks_used + 1;
      if (o_ppfifo_stb) begin
        i_ppfifo_data <= i_ppfifo_data + 32'd1;
        stb_n         <= stb_n + 1;
      end
      if (o_write_finished) fin_n <= fin_n + 1;
      if (o_mem_cyc && o_mem_stb && o_mem_we && i_mem_ack) begin
        wr_adr[wr_n] <= o_mem_adr;
        wr_dat[wr_n] <= o_mem_dat;
        wr_n         <= wr_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm(input logic [1:0] sel, input logic [31:0] base, input logic [31:0] size);
    i_bank_sel  = sel;
    i_bank_base = base;
    i_bank_size = size;
    i_bank_wr   = 1'b1;
    @(negedge clk);
    i_bank_wr   = 1'b0;
  endtask

  task automatic wait_fin(input int target, input string tag);
    int n = 0;
    while (fin_n < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(fin_n), 32'(target));
  endtask

  initial begin
    int n;
    int stb_snap;
    tests = 0; failed = 0;
    rst = 1'b1; i_enable = 1'b0; i_bank_wr = 1'b0; i_bank_sel = 2'd0;
    i_bank_base = 32'd0; i_bank_size = 32'd0; ack_en = 1'b1; blocks_total = 0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_cyc",   32'(o_mem_cyc), 32'd0);
    check("rst_act",   32'(o_ppfifo_act), 32'd0);
    check("rst_cur",   32'(o_cur_bank), 32'd0);
    check("rst_armed", 32'(o_bank_armed), 32'd0);
    check("rst_done",  32'(o_bank_done), 32'd0);
    check("rst_count", o_bank_count, 32'd0);
    check("rst_err",   32'(o_error), 32'd0);

    // Single bank of 4 words from one block
    i_enable = 1'b1;
    blocks_total = 1;
    arm(2'd0, 32'h1000, 32'd4);
    wait_fin(1, "b0_fin");
    tick(2);
    check("b0_wr_n",  32'(wr_n), 32'd4);
    check("b0_adr0",  wr_adr[0], 32'h1000);
    check("b0_adr3",  wr_adr[3], 32'h1003);
    check("b0_dat0",  wr_dat[0], 32'd0);
    check("b0_dat3",  wr_dat[3], 32'd3);
    check("b0_done",  32'(o_bank_done), 32'b0001);
    check("b0_armed", 32'(o_bank_armed), 32'b0000);
    check("b0_cur",   32'(o_cur_bank), 32'd1);
    check("b0_pulse", 32'(fin_n), 32'd1);
    check("b0_count", o_bank_count, 32'd4);
    check("b0_act",   32'(o_ppfifo_act), 32'd0);

    // Re-arming an armed bank is ignored
    arm(2'd1, 32'h2000, 32'd3);
    tick(3);
    arm(2'd1, 32'h9999, 32'd7);
    tick(1);
    check("rearm_base",  o_bank_base, 32'h2000);
    check("rearm_count", o_bank_count, 32'd0);

    // Block straddles into unarmed bank 2: act held, no strobes
    blocks_total = 2;
    wait_fin(2, "b1_fin");
    tick(2);
    stb_snap = stb_n;
    tick(10);
    check("hold_act",  32'(o_ppfifo_act), 32'd1);
    check("hold_stb",  32'(stb_n), 32'(stb_snap));
    check("hold_wr_n", 32'(wr_n), 32'd7);
    check("b1_adr2",   wr_adr[6], 32'h2002);
    check("b1_dat2",   wr_dat[6], 32'd6);
    blocks_total = 3;
    arm(2'd2, 32'h3000, 32'd3);
    wait_fin(3, "b2_fin");
    tick(2);
    check("b2_adr0", wr_adr[7], 32'h3000);
    check("b2_dat0", wr_dat[7], 32'd7);
    check("b2_adr2", wr_adr[9], 32'h3002);
    check("b2_dat2", wr_dat[9], 32'd9);
    check("b2_cur",  32'(o_cur_bank), 32'd3);

    // Enable drop mid-word after 2 of 5 words
    blocks_total = 4;
    arm(2'd3, 32'h4000, 32'd5);
    n = 0;
    while (wr_n < 11 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!o_mem_stb && n < 200) begin @(negedge clk); n++; end
    check("en_stb_seen", 32'(o_mem_stb), 32'd1);
    i_enable = 1'b0;
    tick(10);
    i_bank_sel = 2'd3;
    tick(1);
    check("pause_wr_n",  32'(wr_n), 32'd12);
    check("pause_cyc",   32'(o_mem_cyc), 32'd0);
    check("pause_count", o_bank_count, 32'd2);
    i_enable = 1'b1;
    wait_fin(4, "b3_fin");
    tick(2);
    check("b3_adr2", wr_adr[12], 32'h4002);
    check("b3_dat2", wr_dat[12], 32'd12);
    check("b3_adr4", wr_adr[14], 32'h4004);
    check("b3_dat4", wr_dat[14], 32'd14);
    check("b3_cur",  32'(o_cur_bank), 32'd0);

    // Wrap to bank 0 after re-arming it; done clears on arm
    blocks_total = 5;
    arm(2'd0, 32'h5000, 32'd2);
    check("wrap_done_clr", 32'(o_bank_done[0]), 32'd0);
    wait_fin(5, "wrap_fin");
    tick(2);
    check("wrap_adr0", wr_adr[15], 32'h5000);
    check("wrap_dat0", wr_dat[15], 32'd15);
    check("wrap_adr1", wr_adr[16], 32'h5001);
    check("wrap_dat1", wr_dat[16], 32'd16);
    check("wrap_done", 32'(o_bank_done), 32'b1111);

`ifdef WB_P2M_TIMEOUT_EN
    // Slave never acks: cyc/stb held exactly TIMEOUT_CYCLES clocks
    ack_en = 1'b0;
    arm(2'd1, 32'h6000, 32'd2);
    n = 0;
    while (!o_mem_stb && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (o_mem_stb && n < 100) begin @(negedge clk); n++; end
    check("tmo_len",   32'(n), 32'd16);
    check("tmo_cyc",   32'(o_mem_cyc), 32'd0);
    check("tmo_err",   32'(o_error), 32'd1);
    check("tmo_armed", 32'(o_bank_armed[1]), 32'd0);
    check("tmo_done",  32'(o_bank_done[1]), 32'd0);
    check("tmo_act",   32'(o_ppfifo_act), 32'd0);
`else
    check("no_err", 32'(o_error), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
